// File: rtl/uart_cmd_asm.sv
// uart_cmd_asm: packs received byte pairs into 16-bit commands with timeout and overrun flags
module uart_cmd_asm #(
  parameter int TIMEOUT = 78120,
  parameter int TO_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_ovr,
  output logic        to_err
);
  typedef enum logic {IDLE, WAIT_LO} state_t;
  state_t state, nxt;
  logic [7:0] hi;
  logic [TO_W-1:0] timer;
  logic done, tmo;
  assign clr_rdy = rdy & rst_n;
  always_comb begin
    done = state == WAIT_LO && rdy;
    tmo = state == WAIT_LO && !rdy && timer == TO_W'(TIMEOUT - 1);
    nxt = state == IDLE ? (rdy ? WAIT_LO : IDLE) : (rdy || tmo ? IDLE : WAIT_LO);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi <= '0;
      timer <= '0;
      cmd <= '0;
      cmd_rdy <= 1'b0;
      cmd_ovr <= 1'b0;
      to_err <= 1'b0;
    end else begin
      state <= nxt;
      hi <= state == IDLE && rdy ? rx_data : hi;
      timer <= state == WAIT_LO && !done && !tmo ? timer + TO_W'(1) : '0;
      to_err <= tmo;
      cmd <= done ? {hi, rx_data} : cmd;
      cmd_rdy <= done | (cmd_rdy & ~clr_cmd_rdy);
      // a completion only flags overrun when the previous command was not acknowledged
      cmd_ovr <= clr_cmd_rdy ? 1'b0 : cmd_ovr | (done & cmd_rdy);
    end
  end
endmodule

// File: tb/tb_uart_cmd_asm.sv
// tb_uart_cmd_asm: directed and random checks of uart_cmd_asm against a cycle-counting model
module tb_uart_cmd_asm;
  localparam int TO = 200;
  localparam int TW = 8;
  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b0, clr_cmd_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic clr_rdy, cmd_rdy, cmd_ovr, to_err;
  logic [15:0] cmd;
  int n_chk = 0, n_fail = 0;
  logic [15:0] m_cmd = '0;
  logic m_rdy = 1'b0, m_ovr = 1'b0, m_to = 1'b0, pend = 1'b0;
  logic [7:0] m_hi = '0;
  int hi_cyc = 0, cyc = 0;
  uart_cmd_asm #(.TIMEOUT(TO), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .cmd_ovr(cmd_ovr), .to_err(to_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  // byte pairing judged from capture-cycle distance, not a running timer
  task automatic model_edge();
    if (!rst_n) begin
      m_cmd = '0; m_rdy = 0; m_ovr = 0; m_to = 0; pend = 0;
    end else begin
      m_to = 0;
      if (rdy && pend) begin
        m_cmd = {m_hi, rx_data};
        m_ovr = clr_cmd_rdy ? 1'b0 : (m_rdy ? 1'b1 : m_ovr);
        m_rdy = 1;
        pend = 0;
      end else begin
        if (clr_cmd_rdy) begin m_rdy = 0; m_ovr = 0; end
        if (rdy) begin pend = 1; m_hi = rx_data; hi_cyc = cyc; end
        else if (pend && cyc == hi_cyc + TO) begin pend = 0; m_to = 1; end
      end
    end
    cyc++;
  endtask
  task automatic tick();
    @(negedge clk);
    chk("clr_rdy", 16'(clr_rdy), 16'(rdy & rst_n));
    chk("cmd", cmd, m_cmd);
    chk("cmd_rdy", 16'(cmd_rdy), 16'(m_rdy));
    chk("cmd_ovr", 16'(cmd_ovr), 16'(m_ovr));
    chk("to_err", 16'(to_err), 16'(m_to));
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rdy = 1; rx_data = b; tick(); rdy = 0; rx_data = $urandom;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic clear();
    clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
  endtask
  initial begin
    idle(2);
    rst_n = 1;
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    chk("rst_ovr", 16'(cmd_ovr), 16'h0);
    chk("rst_to", 16'(to_err), 16'h0);
    send(8'hA5);
    rst_n = 0; tick(); rst_n = 1;
    chk("mid_rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    send(8'h3C); send(8'h81);
    chk("mid_rst_cmd", cmd, 16'h3C81);
    chk("mid_rst_cmd_rdy2", 16'(cmd_rdy), 16'h1);
    clear();
    send(8'h12); idle(TO / 3); send(8'h34);
    chk("pair_cmd", cmd, 16'h1234);
    chk("pair_rdy", 16'(cmd_rdy), 16'h1);
    chk("pair_ovr", 16'(cmd_ovr), 16'h0);
    clear();
    chk("pair_clr_rdy", 16'(cmd_rdy), 16'h0);
    chk("pair_hold", cmd, 16'h1234);
    send(8'hDE); idle(TO - 1);
    chk("to_early", 16'(to_err), 16'h0);
    tick();
    chk("to_pulse", 16'(to_err), 16'h1);
    tick();
    chk("to_once", 16'(to_err), 16'h0);
    chk("to_rdy", 16'(cmd_rdy), 16'h0);
    send(8'h00); send(8'h07);
    chk("after_to", cmd, 16'h0007);
    clear();
    send(8'h11); idle(TO - 1); send(8'h22);
    chk("bound_in", cmd, 16'h1122);
    chk("bound_in_to", 16'(to_err), 16'h0);
    clear();
    send(8'h33); idle(TO);
    chk("bound_out_to", 16'(to_err), 16'h1);
    send(8'h44); send(8'h55);
    chk("bound_out", cmd, 16'h4455);
    clear();
    send(8'hBE); send(8'hEF); send(8'hCA); send(8'hFE);
    chk("ovr_cmd", cmd, 16'hCAFE);
    chk("ovr_rdy", 16'(cmd_rdy), 16'h1);
    chk("ovr_flag", 16'(cmd_ovr), 16'h1);
    clear();
    chk("ovr_clr_rdy", 16'(cmd_rdy), 16'h0);
    chk("ovr_clr_flag", 16'(cmd_ovr), 16'h0);
    send(8'h01); send(8'h02); send(8'h5A);
    clr_cmd_rdy = 1; send(8'h5A); clr_cmd_rdy = 0;
    chk("sim_rdy", 16'(cmd_rdy), 16'h1);
    chk("sim_ovr", 16'(cmd_ovr), 16'h0);
    chk("sim_cmd", cmd, 16'h5A5A);
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst_n = 0; tick(); rst_n = 1;
      end else begin
        clr_cmd_rdy = $urandom_range(0, 3) == 0;
        send(8'($urandom));
        clr_cmd_rdy = 0;
        for (int g = (r < 12 ? $urandom_range(TO - 3, TO + 3) : $urandom_range(0, 5)); g > 0; g--) begin
          clr_cmd_rdy = $urandom_range(0, 7) == 0;
          tick();
        end
        clr_cmd_rdy = 0;
      end
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
